regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Parametrised multi-read-port integer register file with per-register scoreboard
//  (busy bits) for the pipelined RISC-V core. Decode reads operands and reserves the
//  destination register; writeback writes data and releases the reservation.
//  Optional write-to-read bypass. Register 0 is hardwired to zero.
// PARAMETERS
//  XLEN    32  data width in bits
//  NREGS   32  number of architectural registers (power of 2, >=2)
//  NRD     2   number of asynchronous read ports (>=1)
//  BYPASS  1   1: same-cycle write data forwarded to read ports; 0: no forwarding
//  AW      $clog2(NREGS), derived (localparam), register address width
//  CW      $clog2(NREGS+1), derived (localparam), pending counter width
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous, active-low reset
//  rd_addr      in   NRD*AW     read addresses; port i = rd_addr[i*AW +: AW]
//  rd_data      out  NRD*XLEN   read data; port i = rd_data[i*XLEN +: XLEN]
//  rd_busy      out  NRD        1 = port i register has an outstanding reservation
//  wr_en        in   1          writeback strobe
//  wr_addr      in   AW         writeback destination
//  wr_data      in   XLEN       writeback data
//  rsv_en       in   1          reservation request from decode
//  rsv_addr     in   AW         register to reserve
//  rsv_ok       out  1          reservation granted this cycle (combinational)
//  pending_cnt  out  CW         number of registers currently busy
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): all registers <= 0, all busy bits <= 0,
//   pending_cnt = 0; hence rd_data = 0, rd_busy = 0, rsv_ok = 0 while in reset.
//  Reads: combinational, zero latency. Address 0 -> rd_data=0, rd_busy=0.
//   BYPASS=1 and wr_en && wr_addr==rd_addr!=0: rd_data=wr_data, rd_busy=0.
//   Otherwise rd_data = reg[addr], rd_busy = busy[addr].
//  Writes: on posedge clk when wr_en && wr_addr!=0: reg[wr_addr] <= wr_data and
//   busy[wr_addr] <= 0. Write to x0 ignored. Write to non-busy reg is legal.
//  Reservations (combinational grant, registered effect):
//   rsv_ok = rsv_en && (rsv_addr==0 || !busy[rsv_addr] || (wr_en && wr_addr==rsv_addr)).
//   On posedge, rsv_ok && rsv_addr!=0: busy[rsv_addr] <= 1.
//   Reservation of a busy reg without same-cycle release: rsv_ok=0, no state change
//   (decode stalls on WAW). rsv_addr==0: rsv_ok=1, no state change.
//  Same-cycle write and reservation of the same reg: write data lands, busy stays 1
//   (reservation wins), pending_cnt unchanged.
//  pending_cnt: +1 per granted reservation that sets a clear bit, -1 per write that
//   clears a set bit, net applied same edge; always equals popcount(busy); never
//   wraps (max NREGS-1 since x0 never busy).
//  No other state; no FSM beyond busy bits. rst_n assertion mid-operation discards
//   all reservations and data immediately, regardless of clk.
// TESTING
//  1. Reset, then read all regs on every port -> rd_data=0, rd_busy=0, pending_cnt=0.
//  2. Write x5=0xDEADBEEF, x0=0x1234; next cycle read x5,x0 -> 0xDEADBEEF, 0.
//  3. BYPASS=1: wr_en x7=0xA5A5A5A5 while port1 reads x7 -> same cycle 0xA5A5A5A5,
//     rd_busy=0; BYPASS=0 -> old value returned that cycle.
//  4. Reserve x3 -> rsv_ok=1, next cycle rd_busy=1, pending_cnt=1; reserve x3 again
//     -> rsv_ok=0; write x3=0x11 -> busy clears, pending_cnt=0.
//  5. x9 busy; same cycle wr x9=0x22 and rsv x9 -> rsv_ok=1, x9 reads 0x22,
//     busy stays 1, pending_cnt unchanged.
//  6. Reserve x1..x31 over 31 cycles -> pending_cnt=31; drop rst_n mid-clock ->
//     pending_cnt=0 and all rd_busy=0 immediately.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with per-register busy scoreboard.
// Decode reserves destinations (busy bits), writeback writes data and releases them.
// Register 0 reads as zero, is never written and is never busy.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS),
    localparam int CW    = $clog2(NREGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic                rsv_ok,
    output logic [CW-1:0]       pending_cnt
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [CW-1:0]    r_cnt;

    logic w_wr;       // effective write (x0 filtered out)
    logic w_rsv_set;  // granted reservation that targets a real register
    logic w_inc;
    logic w_dec;

    assign w_wr      = wr_en && (wr_addr != '0);
    // Gated by rst_n so that no grant is visible while the scoreboard is held in reset.
    assign rsv_ok    = rst_n && rsv_en &&
                       ((rsv_addr == '0) || !r_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
    assign w_rsv_set = rsv_ok && (rsv_addr != '0);
    // A same-register write+reserve keeps the bit set, so neither side counts.
    assign w_inc     = w_rsv_set && !r_busy[rsv_addr];
    assign w_dec     = w_wr && r_busy[wr_addr] && !(w_rsv_set && (rsv_addr == wr_addr));

    assign pending_cnt = r_cnt;

    // Asynchronous read ports with optional same-cycle write forwarding.
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_zero;
        logic          w_byp;
        assign w_ra   = rd_addr[g*AW +: AW];
        assign w_zero = (w_ra == '0);
        assign w_byp  = (BYPASS != 0) && rst_n && wr_en && (wr_addr == w_ra);
        assign rd_data[g*XLEN +: XLEN] = w_zero ? '0 : (w_byp ? wr_data : r_regs[w_ra]);
        assign rd_busy[g]              = w_zero ? 1'b0 : (w_byp ? 1'b0 : r_busy[w_ra]);
    end

    // Register array: writeback stores data, x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Busy bits: release on write, then set on reservation so a same-register reserve wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (w_wr) begin
                r_busy[wr_addr] <= 1'b0;
            end
            if (w_rsv_set) begin
                r_busy[rsv_addr] <= 1'b1;
            end
        end
    end

    // Pending counter tracks popcount(busy) by applying the net change each edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a forwarding instance and a
// non-forwarding instance share all inputs; expected values are hand-computed.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = 6;
    localparam int NRD  = 2;

    logic                clk;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD*XLEN-1:0] nb_rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NRD-1:0]      nb_rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic                rsv_ok;
    logic                nb_rsv_ok;
    logic [CW-1:0]       pending_cnt;
    logic [CW-1:0]       nb_pending_cnt;

    int n_total;
    int n_bad;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
        .pending_cnt(pending_cnt)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(nb_rsv_ok),
        .pending_cnt(nb_pending_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; combinational outputs settle #1 later.
    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en = 1'b0; rsv_en = 1'b0;
    endtask

    initial begin
        n_total = 0; n_bad = 0;
        rst_n = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b1; rsv_addr = 5'd4;
        #1;
        chk("rst_rsv_ok", {31'd0, rsv_ok}, 32'd0);
        chk("rst_cnt", {26'd0, pending_cnt}, 32'd0);
        rsv_en = 1'b0;
        repeat (2) @(posedge clk);
        to_neg(); rst_n = 1'b1;

        // 1. every register reads 0 / not busy on both ports
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            chk("t1_d0", rd_data[31:0], 32'd0);
            chk("t1_d1", rd_data[63:32], 32'd0);
            chk("t1_busy", {30'd0, rd_busy}, 32'd0);
        end
        chk("t1_cnt", {26'd0, pending_cnt}, 32'd0);

        // 2. write x5, attempt x0
        to_neg(); wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        to_neg(); wr_addr = 5'd0; wr_data = 32'h00001234;
        to_neg(); idle(); rd_addr = {5'd0, 5'd5};
        #1;
        chk("t2_x5", rd_data[31:0], 32'hDEADBEEF);
        chk("t2_x0", rd_data[63:32], 32'd0);
        chk("t2_cnt", {26'd0, pending_cnt}, 32'd0);

        // 3. write-to-read forwarding on port 1
        to_neg(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; rd_addr = {5'd7, 5'd5};
        #1;
        chk("t3_byp_d", rd_data[63:32], 32'hA5A5A5A5);
        chk("t3_byp_busy", {31'd0, rd_busy[1]}, 32'd0);
        chk("t3_nobyp_d", nb_rd_data[63:32], 32'd0);
        to_neg(); idle();
        #1;
        chk("t3_nobyp_after", nb_rd_data[63:32], 32'hA5A5A5A5);

        // 4. reserve x3, WAW stall, release by write
        to_neg(); rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        chk("t4_ok", {31'd0, rsv_ok}, 32'd1);
        to_neg(); rsv_en = 1'b0; rd_addr = {5'd0, 5'd3};
        #1;
        chk("t4_busy", {31'd0, rd_busy[0]}, 32'd1);
        chk("t4_cnt1", {26'd0, pending_cnt}, 32'd1);
        rsv_en = 1'b1; rsv_addr = 5'd3;
        #1;
        chk("t4_stall", {31'd0, rsv_ok}, 32'd0);
        to_neg(); rsv_en = 1'b0;
        #1;
        chk("t4_cnt_stall", {26'd0, pending_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        to_neg(); idle();
        #1;
        chk("t4_busy_clr", {31'd0, rd_busy[0]}, 32'd0);
        chk("t4_cnt0", {26'd0, pending_cnt}, 32'd0);
        chk("t4_data", rd_data[31:0], 32'h11);

        // x0 reservation: granted, no state change
        rsv_en = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("t4_x0_ok", {31'd0, rsv_ok}, 32'd1);
        to_neg(); idle();
        #1;
        chk("t4_x0_cnt", {26'd0, pending_cnt}, 32'd0);

        // 5. same-cycle write and reserve of busy x9
        rsv_en = 1'b1; rsv_addr = 5'd9;
        to_neg(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h22; rd_addr = {5'd0, 5'd9};
        #1;
        chk("t5_ok", {31'd0, rsv_ok}, 32'd1);
        chk("t5_cnt_pre", {26'd0, pending_cnt}, 32'd1);
        to_neg(); idle();
        #1;
        chk("t5_data", rd_data[31:0], 32'h22);
        chk("t5_busy", {31'd0, rd_busy[0]}, 32'd1);
        chk("t5_cnt", {26'd0, pending_cnt}, 32'd1);
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h23;
        to_neg(); idle();
        #1;
        chk("t5_cnt_rel", {26'd0, pending_cnt}, 32'd0);

        // 6. fill the scoreboard, then asynchronous reset mid-cycle
        for (int r = 1; r < 32; r++) begin
            rsv_en = 1'b1; rsv_addr = 5'(r);
            #1;
            chk("t6_ok", {31'd0, rsv_ok}, 32'd1);
            to_neg();
        end
        idle();
        #1;
        chk("t6_cnt31", {26'd0, pending_cnt}, 32'd31);
        chk("t6_nb_cnt31", {26'd0, nb_pending_cnt}, 32'd31);
        rd_addr = {5'd31, 5'd1};
        #1;
        chk("t6_busy_pre", {30'd0, rd_busy}, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_cnt_rst", {26'd0, pending_cnt}, 32'd0);
        chk("t6_nb_cnt_rst", {26'd0, nb_pending_cnt}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #0.1;
            chk("t6_busy_rst", {30'd0, rd_busy}, 32'd0);
            chk("t6_data_rst", rd_data[31:0] | rd_data[63:32], 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
